// File: rtl/param_sequence_detector.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, overlap select, saturating match count.
// Latency: det_o asserts on the edge sampling the final pattern bit; no backpressure, valid_i gaps freeze history.
// Build option: define DET_MASK_EN to add the mask_i don't-care port.
module param_sequence_detector #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_i,
    input  logic             valid_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             pat_load_i,
    input  logic             overlap_i,
    input  logic             cnt_clr_i,
`ifdef DET_MASK_EN
    input  logic [PAT_W-1:0] mask_i,
`endif
    output logic             det_o,
    output logic [CNT_W-1:0] det_cnt_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  cand;
    logic [PAT_W-1:0]  diff;
    logic              hit;

    // The incoming bit completes the candidate window, so a match is seen on its own edge.
    always_comb begin
        cand = {hist, x_i};
        diff = cand ^ pat_q;
`ifdef DET_MASK_EN
        diff = diff & ~mask_i;
`endif
        hit  = valid_i && !pat_load_i && (fill >= FILL_LAST) && (diff == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q     <= DEFAULT_PAT;
            hist      <= '0;
            fill      <= '0;
            det_o     <= 1'b0;
            det_cnt_o <= '0;
        end else begin
            det_o <= 1'b0;
            if (pat_load_i) begin
                // A bit arriving with the load is dropped; the new pattern starts from an empty window.
                pat_q <= pattern_i;
                hist  <= '0;
                fill  <= '0;
            end else if (valid_i) begin
                hist  <= cand[PAT_W-2:0];
                det_o <= hit;
                if (hit && !overlap_i)
                    fill <= '0;
                else if (fill != FILL_FULL)
                    fill <= fill + FILL_W'(1);
            end

            if (cnt_clr_i)
                det_cnt_o <= '0;
            else if (hit && (det_cnt_o != '1))
                det_cnt_o <= det_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: an 8-bit-counter and a 2-bit-counter instance share stimulus.
module tb_param_sequence_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       x_i, valid_i, pat_load_i, overlap_i, cnt_clr_i;
    logic [3:0] pattern_i;
    logic [3:0] mask_i;
    logic       det_a, det_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    param_sequence_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i),
        .pattern_i(pattern_i), .pat_load_i(pat_load_i), .overlap_i(overlap_i),
        .cnt_clr_i(cnt_clr_i),
`ifdef DET_MASK_EN
        .mask_i(mask_i),
`endif
        .det_o(det_a), .det_cnt_o(cnt_a)
    );

    param_sequence_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i),
        .pattern_i(pattern_i), .pat_load_i(pat_load_i), .overlap_i(overlap_i),
        .cnt_clr_i(cnt_clr_i),
`ifdef DET_MASK_EN
        .mask_i(mask_i),
`endif
        .det_o(det_b), .det_cnt_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock edge with the given bit; det_o is checked 1ns after the edge.
    task automatic step(input logic x, input logic v, input logic exp, input string tag);
        x_i = x;
        valid_i = v;
        @(posedge clk);
        #1;
        chk(tag, {31'b0, det_a}, {31'b0, exp});
        valid_i = 1'b0;
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--)
            step(bits[i], 1'b1, exp[i], $sformatf("%s_bit%0d", tag, n - i));
    endtask

    task automatic load(input logic [3:0] pat, input logic clr);
        pattern_i  = pat;
        pat_load_i = 1'b1;
        cnt_clr_i  = clr;
        x_i        = 1'b1;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        chk("load_no_pulse", {31'b0, det_a}, 32'd0);
        pat_load_i = 1'b0;
        cnt_clr_i  = 1'b0;
        valid_i    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        x_i = 1'b0; valid_i = 1'b0; pat_load_i = 1'b0; overlap_i = 1'b1;
        cnt_clr_i = 1'b0; pattern_i = 4'b0000; mask_i = 4'b0000;
        #12;
        chk("rst_det", {31'b0, det_a}, 32'd0);
        chk("rst_cnt", {24'b0, cnt_a}, 32'd0);
        chk("rst_cnt2", {30'b0, cnt_b}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Overlapping: pulses on bits 5, 8, 11.
        overlap_i = 1'b1;
        stream(16'b1101_1011_0111, 16'b0000_1001_0010, 12, "ovl");
        chk("ovl_cnt", {24'b0, cnt_a}, 32'd3);
        load(4'b1011, 1'b1);
        chk("clr_cnt", {24'b0, cnt_a}, 32'd0);

        // Non-overlapping: pulses on bits 5 and 11 only.
        overlap_i = 1'b0;
        stream(16'b1101_1011_0111, 16'b0000_1000_0010, 12, "novl");
        chk("novl_cnt", {24'b0, cnt_a}, 32'd2);
        load(4'b1011, 1'b1);
        overlap_i = 1'b1;

        // Valid gaps freeze history.
        stream(16'b10, 16'b00, 2, "gap_pre");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, $sformatf("gap_idle%0d", i));
        stream(16'b11, 16'b01, 2, "gap_post");

        // Pattern load discards the simultaneous bit and restarts fill.
        stream(16'b101, 16'b000, 3, "ld_pre");
        load(4'b0110, 1'b0);
        stream(16'b0110, 16'b0001, 4, "ld_post");

        // Mid-cycle asynchronous reset while det_o is high.
        stream(16'b0110, 16'b0001, 4, "prerst");
        #2 reset = 1'b0;
        #1;
        chk("arst_det", {31'b0, det_a}, 32'd0);
        chk("arst_cnt", {24'b0, cnt_a}, 32'd0);
        chk("arst_cnt2", {30'b0, cnt_b}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        stream(16'b1011, 16'b0001, 4, "postrst");

        // Saturation of the 2-bit counter after 5 matches.
        stream(16'b0110_1101_1011, 16'b0010_0100_1001, 12, "sat");
        chk("sat_cnt2", {30'b0, cnt_b}, 32'd3);
        chk("sat_cnt", {24'b0, cnt_a}, 32'd5);
        step(1'b0, 1'b1, 1'b0, "clrm_b1");
        step(1'b1, 1'b1, 1'b0, "clrm_b2");
        cnt_clr_i = 1'b1;
        step(1'b1, 1'b1, 1'b1, "clrm_b3");
        cnt_clr_i = 1'b0;
        chk("clrm_cnt", {24'b0, cnt_a}, 32'd0);
        chk("clrm_cnt2", {30'b0, cnt_b}, 32'd0);

        // Don't-care mask on the LSB; the exact build must reject the same stream.
        mask_i = 4'b0001;
        load(4'b1011, 1'b0);
`ifdef DET_MASK_EN
        stream(16'b1010, 16'b0001, 4, "mask");
`else
        stream(16'b1010, 16'b0000, 4, "exact");
`endif
        mask_i = 4'b0000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
